universal_shift_reg: RTL and testbench
======================================

# universal_shift_reg

Parametrised W-bit register with synchronous enable and eight operating modes: hold, parallel load, logical shift left/right, rotate left/right, arithmetic shift right, and clear. It extends the plain enabled data register with serial in/out and status flags. It is used as a general-purpose datapath register in serial converters, multiply/divide sequencers and bit-stream generators. Every state change happens on the rising clock edge, with one-cycle latency.

## Interface
- WIDTH, 7, register width in bits; legal range 2..64
- RESET_VAL, {WIDTH{1'b0}}, value loaded into q on reset
- clk  input  1  rising-edge clock; the only clock
- rst  input  1  reset, synchronous, active-low; takes effect on the clk rising edge while low
- en  input  1  synchronous enable; 0 forces hold regardless of mode
- mode  input  3  operation select, decoded below
- d  input  WIDTH  parallel load data
- sin  input  1  serial input bit for shift modes
- q  output  WIDTH  register contents (registered)
- sout  output  1  last bit shifted or rotated out (registered)
- zero  output  1  registered flag; 1 when the q value written on this edge equals 0

## Operation
- Priority at each rising clk: rst==0, then en==0, then mode.
- rst==0: q=RESET_VAL, sout=0, zero=(RESET_VAL==0).
- en==0: q, sout and zero hold.
- en==1, mode decode (q' = next value; q[W-1] = MSB):
  - 000 hold: q'=q; sout and zero hold.
  - 001 load: q'=d; sout holds.
  - 010 shift left logical: q'={q[W-2:0],sin}; sout'=q[W-1].
  - 011 shift right logical: q'={sin,q[W-1:1]}; sout'=q[0].
  - 100 rotate left: q'={q[W-2:0],q[W-1]}; sout'=q[W-1]; sin ignored.
  - 101 rotate right: q'={q[0],q[W-1:1]}; sout'=q[0]; sin ignored.
  - 110 arithmetic shift right: q'={q[W-1],q[W-1:1]}; sout'=q[0]; sin ignored.
  - 111 clear: q'=0; sout'=0.
- zero' = (q'==0) whenever q is written (modes 001–111). The flag is computed from the new value, not the old one.
- No X propagation: every mode value is decoded, and there is no default-case latch.
- sin, d and mode are sampled only on the edge. Glitches between edges have no effect.

## Timing
- Latency: one cycle. Inputs sampled at edge N appear on q/sout/zero after edge N, before edge N+1.
- Reset mid-operation overrides any mode on the same edge. The first functional edge is the first edge with rst==1.
- Deasserting en mid-sequence freezes q, sout and zero exactly. Reasserting en resumes from the frozen value with no lost or extra shift.
- Back-to-back shifts:
  - W consecutive shift-left edges with sin=0 empty any value to 0.
  - W consecutive rotates return the original value.
- Mode changes take effect on the next edge. There are no pipeline bubbles or holdover.
- Outputs are glitch-free register outputs, with no combinational path from inputs to outputs.

## Test plan
- Reset: rst=0 for 2 edges with en=1, mode=001, d=7'h55 -> q=0, sout=0, zero=1. Release rst, load 7'h55 -> q=7'h55 after the next edge, zero=0.
- Enable gating: q=7'b1010101, en=0, mode=010, toggle sin for 4 edges -> q stays 7'b1010101 and sout stays unchanged. Set en=1 for one edge with sin=1 -> q=7'b0101011, sout=1.
- Shift right: q=7'b1000001, mode=011, sin=0 for 7 edges -> sout sequence 1,0,0,0,0,0,1; final q=0, zero=1 on the 7th edge.
- Rotate / ASR: load 7'b1000110, rotate left 7 edges -> q returns to 7'b1000110. Then mode=110 for 3 edges -> q=7'b1111000, sout=1.
- Clear and reset priority: q=7'h7F, en=1, mode=111 -> q=0, sout=0, zero=1. Next, rst=0 with en=1, mode=001, d=7'h12 on the same edge -> q=RESET_VAL (0).
- Width sweep: repeat the shift-left test with WIDTH=2 and WIDTH=16 (RESET_VAL=16'hA5A5) -> reset q=16'hA5A5, zero=0. A single shift left with sin=1 gives q=16'h4B4B, sout=1.

Source files
------------

// File: rtl/universal_shift_reg.sv
// W-bit enabled register with load, logical/arithmetic shifts, rotates and clear, plus serial-out and zero flags.
// One-cycle latency from sampled inputs to q/sout/zero; en=0 freezes all state.
module universal_shift_reg #(
  parameter int                 WIDTH     = 7,
  parameter logic [WIDTH-1:0]   RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin,
  output logic [WIDTH-1:0] q,
  output logic             sout,
  output logic             zero
);

  localparam logic [2:0] M_HOLD = 3'b000;
  localparam logic [2:0] M_LOAD = 3'b001;
  localparam logic [2:0] M_SLL  = 3'b010;
  localparam logic [2:0] M_SRL  = 3'b011;
  localparam logic [2:0] M_ROL  = 3'b100;
  localparam logic [2:0] M_ROR  = 3'b101;
  localparam logic [2:0] M_ASR  = 3'b110;
  localparam logic [2:0] M_CLR  = 3'b111;

  logic [WIDTH-1:0] q_q, q_d;
  logic             sout_q, sout_d;
  logic             zero_q, zero_d;

  always_comb begin
    q_d    = q_q;
    sout_d = sout_q;
    zero_d = zero_q;
    if (en) begin
      case (mode)
        M_HOLD: q_d = q_q;
        M_LOAD: q_d = d;
        M_SLL: begin
          q_d    = {q_q[WIDTH-2:0], sin};
          sout_d = q_q[WIDTH-1];
        end
        M_SRL: begin
          q_d    = {sin, q_q[WIDTH-1:1]};
          sout_d = q_q[0];
        end
        M_ROL: begin
          q_d    = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
          sout_d = q_q[WIDTH-1];
        end
        M_ROR: begin
          q_d    = {q_q[0], q_q[WIDTH-1:1]};
          sout_d = q_q[0];
        end
        M_ASR: begin
          q_d    = {q_q[WIDTH-1], q_q[WIDTH-1:1]};
          sout_d = q_q[0];
        end
        M_CLR: begin
          q_d    = '0;
          sout_d = 1'b0;
        end
      endcase
      // Flag tracks the value being written, so plain hold leaves it alone.
      if (mode != M_HOLD) zero_d = (q_d == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      q_q    <= RESET_VAL;
      sout_q <= 1'b0;
      zero_q <= (RESET_VAL == '0);
    end else begin
      q_q    <= q_d;
      sout_q <= sout_d;
      zero_q <= zero_d;
    end
  end

  assign q    = q_q;
  assign sout = sout_q;
  assign zero = zero_q;

endmodule

// File: tb/tb_universal_shift_reg.sv
// Drives WIDTH=7, 2 and 16 instances with shared stimulus; a reference model pushes expectations that are popped after each edge.
module tb_universal_shift_reg;

  typedef struct packed {
    logic [63:0] q;
    logic        sout;
    logic        zero;
  } st_t;

  logic        clk = 1'b0;
  logic        rst, en, sin;
  logic [2:0]  mode;
  logic [6:0]  d7;
  logic [1:0]  d2;
  logic [15:0] d16;
  logic [6:0]  q7;
  logic [1:0]  q2;
  logic [15:0] q16;
  logic        sout7, sout2, sout16, zero7, zero2, zero16;

  int checks = 0;
  int errors = 0;

  st_t m7, m2, m16;
  st_t sbq[$];

  always #5 clk = ~clk;

  universal_shift_reg #(.WIDTH(7)) dut7 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .d(d7), .sin(sin),
    .q(q7), .sout(sout7), .zero(zero7));

  universal_shift_reg #(.WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .d(d2), .sin(sin),
    .q(q2), .sout(sout2), .zero(zero2));

  universal_shift_reg #(.WIDTH(16), .RESET_VAL(16'hA5A5)) dut16 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .d(d16), .sin(sin),
    .q(q16), .sout(sout16), .zero(zero16));

  function automatic st_t model(int w, st_t s, logic [63:0] rv, logic r, logic e,
                                logic [2:0] m, logic [63:0] dd, logic si);
    st_t         n;
    logic [63:0] mask, top;
    logic        msb, lsb;
    mask = (64'd1 << w) - 64'd1;
    msb  = s.q[w-1];
    lsb  = s.q[0];
    n    = s;
    if (!r) begin
      n.q = rv; n.sout = 1'b0; n.zero = (rv == 64'd0);
    end else if (e) begin
      case (m)
        3'd0: n = s;
        3'd1: n.q = dd & mask;
        3'd2: begin n.q = ((s.q << 1) | {63'd0, si}) & mask; n.sout = msb; end
        3'd3: begin top = {63'd0, si};  n.q = (s.q >> 1) | (top << (w-1)); n.sout = lsb; end
        3'd4: begin n.q = ((s.q << 1) | {63'd0, msb}) & mask; n.sout = msb; end
        3'd5: begin top = {63'd0, lsb}; n.q = (s.q >> 1) | (top << (w-1)); n.sout = lsb; end
        3'd6: begin top = {63'd0, msb}; n.q = (s.q >> 1) | (top << (w-1)); n.sout = lsb; end
        default: begin n.q = 64'd0; n.sout = 1'b0; end
      endcase
      if (m != 3'd0) n.zero = (n.q == 64'd0);
    end
    return n;
  endfunction

  task automatic cmp(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one edge, push model expectations, then pop and compare after the edge.
  task automatic step(input logic r, input logic e, input logic [2:0] m,
                      input logic [63:0] dd, input logic si);
    st_t x;
    rst = r; en = e; mode = m; sin = si;
    d7 = dd[6:0]; d2 = dd[1:0]; d16 = dd[15:0];
    m7  = model(7,  m7,  64'd0,      r, e, m, dd, si);
    m2  = model(2,  m2,  64'd0,      r, e, m, dd, si);
    m16 = model(16, m16, 64'hA5A5,   r, e, m, dd, si);
    sbq.push_back(m7); sbq.push_back(m2); sbq.push_back(m16);
    @(posedge clk); #1;
    x = sbq.pop_front();
    cmp("w7_q", {57'd0, q7}, x.q); cmp("w7_sout", {63'd0, sout7}, {63'd0, x.sout});
    cmp("w7_zero", {63'd0, zero7}, {63'd0, x.zero});
    x = sbq.pop_front();
    cmp("w2_q", {62'd0, q2}, x.q); cmp("w2_sout", {63'd0, sout2}, {63'd0, x.sout});
    cmp("w2_zero", {63'd0, zero2}, {63'd0, x.zero});
    x = sbq.pop_front();
    cmp("w16_q", {48'd0, q16}, x.q); cmp("w16_sout", {63'd0, sout16}, {63'd0, x.sout});
    cmp("w16_zero", {63'd0, zero16}, {63'd0, x.zero});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [6:0] srl_sout;
    srl_sout = 7'b1000001;
    rst = 1'b0; en = 1'b0; mode = 3'd0; sin = 1'b0; d7 = '0; d2 = '0; d16 = '0;
    m7 = 'x; m2 = 'x; m16 = 'x;
    @(negedge clk);

    // Reset holds over a load request
    step(0, 1, 3'd1, 64'h55, 0);
    step(0, 1, 3'd1, 64'h55, 0);
    cmp("rst_q7", {57'd0, q7}, 64'd0);
    cmp("rst_sout7", {63'd0, sout7}, 64'd0);
    cmp("rst_zero7", {63'd0, zero7}, 64'd1);
    cmp("rst_q16", {48'd0, q16}, 64'hA5A5);
    cmp("rst_zero16", {63'd0, zero16}, 64'd0);
    step(1, 1, 3'd1, 64'h55, 0);
    cmp("load_q7", {57'd0, q7}, 64'h55);
    cmp("load_zero7", {63'd0, zero7}, 64'd0);

    // Enable gating
    for (int i = 0; i < 4; i++) step(1, 0, 3'd2, 64'd0, i[0]);
    cmp("gate_q7", {57'd0, q7}, 64'h55);
    cmp("gate_sout7", {63'd0, sout7}, 64'd0);
    step(1, 1, 3'd2, 64'd0, 1);
    cmp("sll_q7", {57'd0, q7}, 64'h2B);
    cmp("sll_sout7", {63'd0, sout7}, 64'd1);

    // Shift right drains the value out through sout
    step(1, 1, 3'd1, 64'h41, 0);
    for (int i = 0; i < 7; i++) begin
      step(1, 1, 3'd3, 64'd0, 0);
      cmp("srl_sout_seq", {63'd0, sout7}, {63'd0, srl_sout[6-i]});
    end
    cmp("srl_q7", {57'd0, q7}, 64'd0);
    cmp("srl_zero7", {63'd0, zero7}, 64'd1);

    // Rotate round-trip, then arithmetic shift right
    step(1, 1, 3'd1, 64'h46, 0);
    for (int i = 0; i < 7; i++) step(1, 1, 3'd4, 64'd0, 1);
    cmp("rol_q7", {57'd0, q7}, 64'h46);
    for (int i = 0; i < 3; i++) step(1, 1, 3'd6, 64'd0, 0);
    cmp("asr_q7", {57'd0, q7}, 64'h78);
    cmp("asr_sout7", {63'd0, sout7}, 64'd1);
    step(1, 1, 3'd5, 64'd0, 0);
    cmp("ror_q7", {57'd0, q7}, 64'h3C);

    // Hold mode with en=1, clear, then reset beats a load
    step(1, 1, 3'd0, 64'h7F, 1);
    cmp("hold_q7", {57'd0, q7}, 64'h3C);
    step(1, 1, 3'd1, 64'h7F, 0);
    step(1, 1, 3'd7, 64'd0, 1);
    cmp("clr_q7", {57'd0, q7}, 64'd0);
    cmp("clr_sout7", {63'd0, sout7}, 64'd0);
    cmp("clr_zero7", {63'd0, zero7}, 64'd1);
    step(0, 1, 3'd1, 64'h12, 0);
    cmp("rstprio_q7", {57'd0, q7}, 64'd0);

    // Narrow width: two shift-lefts empty the register
    step(1, 1, 3'd1, 64'h3, 0);
    step(1, 1, 3'd2, 64'd0, 0);
    cmp("w2_sout_a", {63'd0, sout2}, 64'd1);
    step(1, 1, 3'd2, 64'd0, 0);
    cmp("w2_q_empty", {62'd0, q2}, 64'd0);
    cmp("w2_zero_empty", {63'd0, zero2}, 64'd1);

    // Wide width with non-zero reset value
    step(0, 1, 3'd2, 64'd0, 1);
    cmp("w16_rst_q", {48'd0, q16}, 64'hA5A5);
    step(1, 1, 3'd2, 64'd0, 1);
    cmp("w16_sll_q", {48'd0, q16}, 64'h4B4B);
    cmp("w16_sll_sout", {63'd0, sout16}, 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
